ase_param_fifo: RTL and testbench

Synthesizable, parametrised successor to the queue-based ASE simulation FIFO.
- Pointer-based circular buffer of exactly 2**DEPTH_BASE2 entries.
- Correct full at DEPTH entries; same-cycle push and pop supported.
- Selectable read mode: 1-cycle registered, or show-ahead (first-word-fall-through).
- Used inside ASE for CCI-P request/response staging wherever a deterministic, reset-clean FIFO is needed.

---
 rtl/ase_fifo_pkg.sv | 40 ++++
 rtl/ase_param_fifo_if.sv | 32 +++
 rtl/ase_fifo_ram.sv | 30 +++
 rtl/ase_param_fifo.sv | 114 +++++++++++
 tb/tb_ase_param_fifo.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ase_fifo_pkg.sv
// ase_fifo_pkg: shared types and elaboration-time helpers for ase_param_fifo.
//   fifo_rdmode_t  : read-port flavour (registered vs. show-ahead)
//   fifo_clog2     : ceil(log2()) for sizing pointers
//   fifo_rdmode    : maps the integer SHOWAHEAD parameter onto fifo_rdmode_t
//   fifo_params_ok : legality check of the full parameter set
package ase_fifo_pkg;

  typedef enum logic {
    FIFO_REGISTERED,
    FIFO_SHOWAHEAD
  } fifo_rdmode_t;

  function automatic int unsigned fifo_clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) begin
      width++;
    end
    return width;
  endfunction

  function automatic fifo_rdmode_t fifo_rdmode(input int unsigned showahead);
    return (showahead != 0) ? FIFO_SHOWAHEAD : FIFO_REGISTERED;
  endfunction

  function automatic bit fifo_params_ok(input int unsigned data_width,
                                        input int unsigned depth_base2,
                                        input int unsigned almfull_thresh,
                                        input int unsigned almempty_thresh,
                                        input int unsigned showahead);
    int unsigned depth;
    if (depth_base2 < 1 || depth_base2 > 30) return 1'b0;
    depth = 1 << depth_base2;
    return (data_width >= 1) &&
           (almfull_thresh >= 1) && (almfull_thresh <= depth) &&
           (almempty_thresh <= depth - 1) &&
           (showahead <= 1);
  endfunction

endpackage

// File: rtl/ase_param_fifo_if.sv
// ase_param_fifo_if: producer/consumer bundle of ase_param_fifo.
//   master : the side that pushes/pops (drives wr_en, data_in, rd_en)
//   slave  : the FIFO itself (drives data, flags, count, overflow/underflow)
interface ase_param_fifo_if #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH_BASE2 = 8
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_v;
  logic                  full;
  logic                  alm_full;
  logic                  empty;
  logic                  alm_empty;
  logic [DEPTH_BASE2:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, data_out_v, full, alm_full, empty, alm_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, data_out_v, full, alm_full, empty, alm_empty, count, overflow, underflow
  );

endinterface

// File: rtl/ase_fifo_ram.sv
// ase_fifo_ram: 2**ADDR_WIDTH x DATA_WIDTH storage for ase_param_fifo.
//   clk   : write clock
//   we    : write enable, waddr/wdata captured on the rising edge
//   raddr : read address, rdata follows it combinationally
// The array is deliberately not reset; the FIFO's pointers decide what is live.
module ase_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ase_param_fifo.sv
// ase_param_fifo: pointer-based circular FIFO of 2**DEPTH_BASE2 entries.
//   clk : rising-edge clock
//   rst : synchronous, active-low reset
//   bus : slave side of ase_param_fifo_if
//         wr_en/data_in push, rd_en pop, data_out/data_out_v read data,
//         full/alm_full/empty/alm_empty/count occupancy, overflow/underflow rejects
// SHOWAHEAD=0 presents popped data one cycle after rd_en; SHOWAHEAD=1 shows the
// head word whenever the FIFO is non-empty and rd_en consumes it.
module ase_param_fifo
  import ase_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned DEPTH_BASE2     = 8,
  parameter int unsigned ALMFULL_THRESH  = 5,
  parameter int unsigned ALMEMPTY_THRESH = 1,
  parameter int unsigned SHOWAHEAD       = 0
) (
  input logic           clk,
  input logic           rst,
  ase_param_fifo_if.slave bus
);

  localparam int unsigned  Depth  = 1 << DEPTH_BASE2;
  localparam int unsigned  PtrW   = fifo_clog2(Depth);
  localparam int unsigned  CntW   = DEPTH_BASE2 + 1;
  localparam fifo_rdmode_t RdMode = fifo_rdmode(SHOWAHEAD);

  localparam logic [CntW-1:0] CntFull     = CntW'(Depth);
  localparam logic [CntW-1:0] CntAlmFull  = CntW'(Depth - ALMFULL_THRESH);
  localparam logic [CntW-1:0] CntAlmEmpty = CntW'(ALMEMPTY_THRESH);

  if (!fifo_params_ok(DATA_WIDTH, DEPTH_BASE2, ALMFULL_THRESH, ALMEMPTY_THRESH, SHOWAHEAD))
  begin : g_param_check
    $error("ase_param_fifo: illegal parameter combination");
  end

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags decode the count register only, so they lag an accepted push/pop by one edge.
  always_comb begin
    full  = (count_q == CntFull);
    empty = (count_q == '0);
  end

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.alm_full  = (count_q >= CntAlmFull);
  assign bus.alm_empty = (count_q <= CntAlmEmpty);
  assign bus.count     = count_q;
  assign bus.overflow  = bus.wr_en & full;
  assign bus.underflow = bus.rd_en & empty;

  always_comb begin
    wr_acc   = bus.wr_en & ~full;
    rd_acc   = bus.rd_en & ~empty;
    wr_ptr_d = wr_ptr_q + PtrW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PtrW'(rd_acc);
    count_d  = count_q + CntW'(wr_acc) - CntW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ase_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PtrW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & rst),  // reset wins over a concurrent push
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  if (RdMode == FIFO_REGISTERED) begin : g_registered
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_v_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        dout_q   <= '0;
        dout_v_q <= 1'b0;
      end else begin
        dout_v_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= ram_rdata;
        end
      end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_out_v = dout_v_q;
  end else begin : g_showahead
    // Masked while empty so stale storage never leaks out, including right after reset.
    assign bus.data_out   = empty ? '0 : ram_rdata;
    assign bus.data_out_v = ~empty;
  end

endmodule

// File: tb/tb_ase_param_fifo.sv
module tb_ase_param_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned DB2   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFT   = 1;
  localparam int unsigned AET   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  always #5 clk = ~clk;

  ase_param_fifo_if #(.DATA_WIDTH(DW), .DEPTH_BASE2(DB2)) bus_reg ();
  ase_param_fifo_if #(.DATA_WIDTH(DW), .DEPTH_BASE2(DB2)) bus_sa ();

  assign bus_reg.wr_en   = wr_en;
  assign bus_reg.rd_en   = rd_en;
  assign bus_reg.data_in = data_in;
  assign bus_sa.wr_en    = wr_en;
  assign bus_sa.rd_en    = rd_en;
  assign bus_sa.data_in  = data_in;

  ase_param_fifo #(
    .DATA_WIDTH(DW), .DEPTH_BASE2(DB2), .ALMFULL_THRESH(AFT), .ALMEMPTY_THRESH(AET),
    .SHOWAHEAD(0)
  ) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (bus_reg)
  );

  ase_param_fifo #(
    .DATA_WIDTH(DW), .DEPTH_BASE2(DB2), .ALMFULL_THRESH(AFT), .ALMEMPTY_THRESH(AET),
    .SHOWAHEAD(1)
  ) u_sa (
    .clk (clk),
    .rst (rst),
    .bus (bus_sa)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words plus the registered-read output.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_dv = 1'b0;

  always @(posedge clk) begin
    logic wa, ra;
    if (!rst) begin
      mq.delete();
      m_dv   = 1'b0;
      m_dout = '0;
    end else begin
      wa   = wr_en && (mq.size() < DEPTH);
      ra   = rd_en && (mq.size() != 0);
      m_dv = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(data_in);
    end
  end

  task automatic chk_flags(input string tag, input int n, input logic [DB2:0] cnt,
                           input logic f, input logic af, input logic e, input logic ae);
    chk({tag, ".count"}, cnt, n);
    chk({tag, ".full"}, f, n == DEPTH);
    chk({tag, ".alm_full"}, af, n >= DEPTH - AFT);
    chk({tag, ".empty"}, e, n == 0);
    chk({tag, ".alm_empty"}, ae, n <= AET);
  endtask

  // Per-cycle compare: state outputs at negedge, combinational rejects once inputs settle.
  always begin
    int n;
    @(negedge clk);
    n = mq.size();
    chk_flags("reg", n, bus_reg.count, bus_reg.full, bus_reg.alm_full, bus_reg.empty,
              bus_reg.alm_empty);
    chk_flags("sa", n, bus_sa.count, bus_sa.full, bus_sa.alm_full, bus_sa.empty,
              bus_sa.alm_empty);
    chk("reg.data_out_v", bus_reg.data_out_v, m_dv);
    chk("reg.data_out", bus_reg.data_out, m_dout);
    chk("sa.data_out_v", bus_sa.data_out_v, n != 0);
    if (n != 0) chk("sa.data_out", bus_sa.data_out, mq[0]);
    #3;
    n = mq.size();
    chk("reg.overflow", bus_reg.overflow, wr_en && n == DEPTH);
    chk("reg.underflow", bus_reg.underflow, rd_en && n == 0);
    chk("sa.overflow", bus_sa.overflow, wr_en && n == DEPTH);
    chk("sa.underflow", bus_sa.underflow, rd_en && n == 0);
  end

  task automatic apply(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    #1;
    tick();
    chk("lit.rst_count", bus_reg.count, 0);
    chk("lit.rst_empty", bus_reg.empty, 1);
    chk("lit.rst_alm_empty", bus_reg.alm_empty, 1);
    chk("lit.rst_full", bus_reg.full, 0);
    chk("lit.rst_dv", bus_reg.data_out_v, 0);
    chk("lit.rst_dout", bus_reg.data_out, 0);
    rst = 1'b1;

    // Fill to full, then one rejected push.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, DW'(16'hA0 + i), 1'b0);
      tick();
      chk("lit.fill_count", bus_reg.count, i + 1);
      chk("lit.fill_alm_full", bus_reg.alm_full, i >= 2);
      chk("lit.fill_full", bus_reg.full, i == 3);
    end
    apply(1'b1, 16'hA4, 1'b0);
    chk("lit.ovf", bus_reg.overflow, 1);
    tick();
    chk("lit.ovf_count", bus_reg.count, 4);
    chk("lit.sa_head", bus_sa.data_out, 16'hA0);

    // Drain in order, then an ignored pop.
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, '0, 1'b1);
      tick();
      chk("lit.drain_dout", bus_reg.data_out, 16'hA0 + i);
      chk("lit.drain_dv", bus_reg.data_out_v, 1);
    end
    chk("lit.drain_empty", bus_reg.empty, 1);
    apply(1'b0, '0, 1'b1);
    chk("lit.udf", bus_reg.underflow, 1);
    tick();
    chk("lit.udf_dv", bus_reg.data_out_v, 0);
    chk("lit.udf_hold", bus_reg.data_out, 16'hA3);

    // Show-ahead single word.
    apply(1'b1, 16'h55, 1'b0);
    tick();
    chk("lit.sa_dout", bus_sa.data_out, 16'h55);
    chk("lit.sa_dv", bus_sa.data_out_v, 1);
    apply(1'b0, '0, 1'b1);
    tick();
    chk("lit.sa_dv_after", bus_sa.data_out_v, 0);
    chk("lit.sa_empty", bus_sa.empty, 1);

    // Wrap-around with simultaneous push/pop at count 2.
    apply(1'b1, 16'hF0, 1'b0);
    tick();
    apply(1'b1, 16'hF1, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, DW'(i), 1'b1);
      tick();
      chk("lit.wrap_count", bus_reg.count, 2);
    end
    chk("lit.wrap_last", bus_reg.data_out, 16'h7);

    // Full + push + pop: pop accepted, push dropped.
    apply(1'b1, 16'hC0, 1'b0);
    tick();
    apply(1'b1, 16'hC1, 1'b0);
    tick();
    chk("lit.full4", bus_reg.count, 4);
    apply(1'b1, 16'hC2, 1'b1);
    chk("lit.full_both_ovf", bus_reg.overflow, 1);
    tick();
    chk("lit.full_both_count", bus_reg.count, 3);
    chk("lit.full_both_dout", bus_reg.data_out, 16'h8);

    // Empty + push + pop: push accepted, pop ignored.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, '0, 1'b1);
      tick();
    end
    chk("lit.drain2_dout", bus_reg.data_out, 16'hC1);
    apply(1'b1, 16'hD0, 1'b1);
    chk("lit.empty_both_udf", bus_reg.underflow, 1);
    chk("lit.empty_both_ovf", bus_reg.overflow, 0);
    tick();
    chk("lit.empty_both_count", bus_reg.count, 1);
    chk("lit.empty_both_dv", bus_reg.data_out_v, 0);

    // Mid-stream reset at count 3, then fresh data only.
    apply(1'b1, 16'hD1, 1'b0);
    tick();
    apply(1'b1, 16'hD2, 1'b0);
    tick();
    chk("lit.pre_rst_count", bus_reg.count, 3);
    rst = 1'b0;
    apply(1'b1, 16'hEE, 1'b1);
    tick();
    chk("lit.mid_rst_count", bus_reg.count, 0);
    chk("lit.mid_rst_empty", bus_reg.empty, 1);
    chk("lit.mid_rst_dv", bus_reg.data_out_v, 0);
    chk("lit.mid_rst_dout", bus_reg.data_out, 0);
    rst = 1'b1;
    apply(1'b1, 16'h77, 1'b0);
    tick();
    chk("lit.post_rst_sa", bus_sa.data_out, 16'h77);
    apply(1'b0, '0, 1'b1);
    tick();
    chk("lit.post_rst_dout", bus_reg.data_out, 16'h77);
    chk("lit.post_rst_dv", bus_reg.data_out_v, 1);

    // Randomised traffic with alternating fill/drain bias and rare resets.
    for (int c = 0; c < 600; c++) begin
      logic w, r;
      if ((c % 150) < 75) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 63) != 0);
      apply(w, DW'($urandom), r);
      tick();
    end

    rst = 1'b1;
    apply(1'b0, '0, 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
